dtpu_cluster_dispatcher: RTL and testbench
==========================================

Name: dtpu_cluster_dispatcher

Overview:
- Front-end scheduler that feeds several DTPU clusters from one input line stream.
- Data tuples (multi-line, delimited by last) go whole to clusters in round-robin order. Programming messages (ctrl=1) go to one addressed cluster or to all clusters.
- Each dispatched tuple's cluster index is recorded in an order FIFO. The downstream result collector uses it to merge per-cluster partial aggregations back into input order.

Parameters:
- NUM_CLUSTERS, 4, number of downstream DTPU clusters.
- NUM_CLUSTERS_BITS, 2, index width, equal to log2(NUM_CLUSTERS).
- DATA_BUS_WIDTH, 512, line width.
- NUM_PUS_PER_CLUSTER_BITS, 3, PU select field width.
- ORDER_FIFO_DEPTH_BITS, 6, order FIFO depth is 2^N entries (64).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_line  in  DATA_BUS_WIDTH  input line
- in_valid  in  1  input line valid
- in_last  in  1  last line of tuple or message
- in_ctrl  in  1  1 = programming message, 0 = data tuple
- in_mode  in  2  mode field, passed through
- in_pu  in  NUM_PUS_PER_CLUSTER_BITS  PU select, passed through
- in_cluster  in  NUM_CLUSTERS_BITS  target cluster for unicast programming
- in_bcast  in  1  programming message goes to all clusters
- in_ready  out  1  input accepted when valid&ready
- out_line  out  DATA_BUS_WIDTH  shared payload bus to all clusters
- out_last, out_ctrl  out  1 each  registered copies
- out_mode  out  2  registered copy
- out_pu  out  NUM_PUS_PER_CLUSTER_BITS  registered copy
- out_valid  out  NUM_CLUSTERS  per-cluster valid mask
- out_ready  in  NUM_CLUSTERS  per-cluster ready
- order_out  out  NUM_CLUSTERS_BITS  cluster index of oldest outstanding tuple
- order_valid  out  1  order FIFO not empty
- order_ready  in  1  pop order FIFO
- tuples_dispatched  out  32  status counter
- prog_lines  out  32  status counter

Behaviour:
- Single output register holds the shared payload plus a valid mask (out_valid).
  - Bit k clears on the cycle out_ready[k]=1.
  - Register is free when (out_valid & ~out_ready)==0.
- in_ready = rst_n & free & ~(state==S_IDLE & ~in_ctrl & order_full).
- An accepted line loads the register next cycle (latency 1). Payload fields are copied; out_valid is set to the target mask.
- Throughput is 1 line/cycle while the targeted clusters hold ready high.
- FSM:
  - S_IDLE, first line of a message. The target mask is computed here.
    - ctrl=1: mask = in_bcast ? all-ones : onehot(in_cluster). If last=0, go to S_PROG.
    - ctrl=0: mask = onehot(rr_ptr); push rr_ptr into the order FIFO. If last=0, go to S_TUPLE.
  - S_TUPLE and S_PROG: the target mask is held; in_ctrl, in_cluster and in_bcast are ignored. An accepted line with last=1 returns to S_IDLE.
- rr_ptr:
  - Advances only on acceptance of a data line with last=1, including a single-line tuple (push and advance in the same cycle).
  - Wraps NUM_CLUSTERS-1 → 0.
  - Programming messages never advance it.
- Broadcast stall: the next line is not accepted until every mask bit has cleared. Partially drained bits stay cleared; accepted clusters never see a duplicate.
- Order FIFO:
  - First-word-fall-through; order_valid = ~empty; pops on order_valid&order_ready.
  - When full, a new tuple start is blocked even if a pop occurs in the same cycle. Lines of an already-started tuple are not blocked.
  - Simultaneous push and pop when not full keeps the count unchanged.
- Counters (32-bit, wrap):
  - tuples_dispatched +1 per accepted data line with last=1.
  - prog_lines +1 per accepted line of a programming message.
- Reset (including mid-message), applied next edge:
  - State S_IDLE, rr_ptr=0.
  - out_valid=0; out_line, out_last, out_ctrl, out_mode, out_pu = 0.
  - Order FIFO emptied, order_valid=0, counters=0, in_ready=0.
  - A partially sent tuple is abandoned.

Test Plan:
1. Reset, all out_ready=1, 5 single-line data tuples back-to-back -> out_valid 0001,0010,0100,1000,0001 on consecutive cycles; order_out 0,1,2,3,0; tuples_dispatched=5.
2. 3-line tuple to cluster 1, out_ready[1]=0 for 4 cycles after line 1 -> in_ready=0 for those cycles, all 3 lines go to cluster 1 only, rr_ptr=2 after last.
3. 2-line broadcast programming message, out_ready[2]=0 for 3 cycles -> out_valid 1111 then 0100 held 3 cycles, line 2 accepted only after clear; rr_ptr unchanged; prog_lines=2.
4. Tuple, unicast programming to cluster 3 (in_bcast=0), tuple -> tuples go to clusters 0 and 1, programming only to 1000; order FIFO holds {0,1}.
5. order_ready=0, 64 single-line tuples then a 65th -> 65th stalled (in_ready=0); pulse order_ready once -> 65th accepted next cycle, order_out=0.
6. Assert rst_n=0 after line 2 of a 4-line tuple -> next cycle out_valid=0, order_valid=0, counters=0. A new tuple after reset goes to cluster 0.

Source files
------------

// File: rtl/dtpu_cluster_dispatcher.sv
// Front-end dispatcher: data tuples go whole to clusters in round-robin order,
// programming messages go to one addressed cluster or to all of them.
module dtpu_cluster_dispatcher #(
    parameter int NUM_CLUSTERS             = 4,
    parameter int NUM_CLUSTERS_BITS        = 2,
    parameter int DATA_BUS_WIDTH           = 512,
    parameter int NUM_PUS_PER_CLUSTER_BITS = 3,
    parameter int ORDER_FIFO_DEPTH_BITS    = 6
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_BUS_WIDTH-1:0]           in_line,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic                                in_ctrl,
    input  logic [1:0]                          in_mode,
    input  logic [NUM_PUS_PER_CLUSTER_BITS-1:0] in_pu,
    input  logic [NUM_CLUSTERS_BITS-1:0]        in_cluster,
    input  logic                                in_bcast,
    output logic                                in_ready,
    output logic [DATA_BUS_WIDTH-1:0]           out_line,
    output logic                                out_last,
    output logic                                out_ctrl,
    output logic [1:0]                          out_mode,
    output logic [NUM_PUS_PER_CLUSTER_BITS-1:0] out_pu,
    output logic [NUM_CLUSTERS-1:0]             out_valid,
    input  logic [NUM_CLUSTERS-1:0]             out_ready,
    output logic [NUM_CLUSTERS_BITS-1:0]        order_out,
    output logic                                order_valid,
    input  logic                                order_ready,
    output logic [31:0]                         tuples_dispatched,
    output logic [31:0]                         prog_lines
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TUPLE = 2'd1;
    localparam logic [1:0] S_PROG  = 2'd2;
    localparam int FIFO_DEPTH = 1 << ORDER_FIFO_DEPTH_BITS;

    logic [1:0]                       state;
    logic [NUM_CLUSTERS-1:0]          held_mask;
    logic [NUM_CLUSTERS-1:0]          target_mask;
    logic [NUM_CLUSTERS_BITS-1:0]     rr_ptr;
    logic [NUM_CLUSTERS_BITS-1:0]     fifo_mem [FIFO_DEPTH];
    logic [ORDER_FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [ORDER_FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [ORDER_FIFO_DEPTH_BITS:0]   count;
    logic free, order_full, first_line, is_prog, accept, push, pop;

    // The register is free once every cluster still holding the line takes it this cycle.
    assign free       = ((out_valid & ~out_ready) == '0);
    assign order_full = count[ORDER_FIFO_DEPTH_BITS];
    assign first_line = (state == S_IDLE);
    assign is_prog    = first_line ? in_ctrl : (state == S_PROG);
    assign in_ready   = rst_n & free & ~(first_line & ~in_ctrl & order_full);
    assign accept     = in_valid & in_ready;
    assign push       = accept & first_line & ~in_ctrl;
    assign pop        = order_valid & order_ready;

    assign order_valid = (count != '0);
    assign order_out   = fifo_mem[rd_ptr];

    // NOTE: every variable in this block gets a default first so no latch is inferred.
    always_comb begin
        target_mask = held_mask;
        if (first_line) begin
            if (in_ctrl)
                target_mask = in_bcast ? '1 : (NUM_CLUSTERS'(1) << in_cluster);
            else
                target_mask = NUM_CLUSTERS'(1) << rr_ptr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            held_mask         <= '0;
            rr_ptr            <= '0;
            out_valid         <= '0;
            out_line          <= '0;
            out_last          <= 1'b0;
            out_ctrl          <= 1'b0;
            out_mode          <= '0;
            out_pu            <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            tuples_dispatched <= '0;
            prog_lines        <= '0;
        end else begin
            out_valid <= out_valid & ~out_ready;
            if (accept) begin
                out_valid <= target_mask;
                out_line  <= in_line;
                out_last  <= in_last;
                out_ctrl  <= is_prog;
                out_mode  <= in_mode;
                out_pu    <= in_pu;
                held_mask <= target_mask;
                if (in_last)
                    state <= S_IDLE;
                else if (first_line)
                    state <= in_ctrl ? S_PROG : S_TUPLE;
                if (is_prog) begin
                    prog_lines <= prog_lines + 32'd1;
                end else if (in_last) begin
                    tuples_dispatched <= tuples_dispatched + 32'd1;
                    rr_ptr <= (rr_ptr == NUM_CLUSTERS_BITS'(NUM_CLUSTERS - 1)) ? '0 : rr_ptr + 1'b1;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                count <= count + 1'b1;
            else if (pop & ~push)
                count <= count - 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= rr_ptr;
    end

endmodule

// File: tb/tb_dtpu_cluster_dispatcher.sv
// Self-checking bench for dtpu_cluster_dispatcher: randomized and directed stimulus,
// a message-level reference model and per-cluster scoreboards.
module tb_dtpu_cluster_dispatcher;

    localparam int NC    = 4;
    localparam int W     = 512;
    localparam int PB    = 3;
    localparam int LIMIT = 200;

    typedef logic [519:0] cv_t;
    typedef struct packed {
        logic [W-1:0]  line;
        logic          last;
        logic          ctrl;
        logic [1:0]    mode;
        logic [PB-1:0] pu;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_line;
    logic          in_valid, in_last, in_ctrl, in_bcast, in_ready;
    logic [1:0]    in_mode;
    logic [PB-1:0] in_pu;
    logic [1:0]    in_cluster;
    logic [W-1:0]  out_line;
    logic          out_last, out_ctrl;
    logic [1:0]    out_mode;
    logic [PB-1:0] out_pu;
    logic [NC-1:0] out_valid, out_ready;
    logic [1:0]    order_out;
    logic          order_valid, order_ready;
    logic [31:0]   tuples_dispatched, prog_lines;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;
    bit rand_done = 0;

    // Reference model state
    item_t       exp_q[NC][$];
    int          order_q[$];
    bit          m_busy, m_prog;
    logic [NC-1:0] m_mask;
    int          m_rr;
    logic [31:0] m_tup, m_prog_cnt;

    dtpu_cluster_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .in_line(in_line), .in_valid(in_valid), .in_last(in_last), .in_ctrl(in_ctrl),
        .in_mode(in_mode), .in_pu(in_pu), .in_cluster(in_cluster), .in_bcast(in_bcast),
        .in_ready(in_ready),
        .out_line(out_line), .out_last(out_last), .out_ctrl(out_ctrl), .out_mode(out_mode),
        .out_pu(out_pu), .out_valid(out_valid), .out_ready(out_ready),
        .order_out(order_out), .order_valid(order_valid), .order_ready(order_ready),
        .tuples_dispatched(tuples_dispatched), .prog_lines(prog_lines)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input cv_t act, input cv_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rl();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: compares the DUT against the model once per cycle, before the rising edge.
    task automatic sample();
        logic [NC-1:0] pend;
        bit   exp_ready;
        item_t it, got;
        int   dummy;
        if (!rst_n) begin
            check("ready_in_reset", cv_t'(in_ready), cv_t'(0));
            for (int k = 0; k < NC; k++) exp_q[k].delete();
            order_q.delete();
            m_busy = 0; m_prog = 0; m_rr = 0; m_tup = 0; m_prog_cnt = 0;
            return;
        end
        for (int k = 0; k < NC; k++) pend[k] = (exp_q[k].size() != 0);
        check("out_valid", cv_t'(out_valid), cv_t'(pend));
        check("order_valid", cv_t'(order_valid), cv_t'(order_q.size() != 0));
        if (order_q.size() != 0) check("order_out", cv_t'(order_out), cv_t'(order_q[0]));
        check("tuples_dispatched", cv_t'(tuples_dispatched), cv_t'(m_tup));
        check("prog_lines", cv_t'(prog_lines), cv_t'(m_prog_cnt));
        exp_ready = ((pend & ~out_ready) == '0) && !(!m_busy && !in_ctrl && order_q.size() == 64);
        check("in_ready", cv_t'(in_ready), cv_t'(exp_ready));
        got = {out_line, out_last, out_ctrl, out_mode, out_pu};
        for (int k = 0; k < NC; k++) begin
            if (pend[k] && out_ready[k]) begin
                it = exp_q[k].pop_front();
                check($sformatf("out_cluster%0d", k), cv_t'(got), cv_t'(it));
            end
        end
        if (order_ready && order_q.size() != 0) dummy = order_q.pop_front();
        if (in_valid && in_ready) begin
            if (!m_busy) begin
                m_prog = in_ctrl;
                m_mask = '0;
                if (in_ctrl) begin
                    if (in_bcast) m_mask = '1;
                    else m_mask[in_cluster] = 1'b1;
                end else begin
                    m_mask[m_rr] = 1'b1;
                    order_q.push_back(m_rr);
                end
            end
            it = {in_line, in_last, m_prog, in_mode, in_pu};
            for (int k = 0; k < NC; k++) if (m_mask[k]) exp_q[k].push_back(it);
            if (m_prog) m_prog_cnt++;
            else if (in_last) begin
                m_tup++;
                m_rr = (m_rr + 1) % NC;
            end
            m_busy = !in_last;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) sample();
        end
    end

    task automatic send(input logic [W-1:0] line, input logic last, input logic ctrl,
                        input logic [1:0] mode, input logic [PB-1:0] pu,
                        input logic [1:0] cl, input logic bc);
        bit acc = 0;
        @(negedge clk);
        in_line = line; in_last = last; in_ctrl = ctrl; in_mode = mode;
        in_pu = pu; in_cluster = cl; in_bcast = bc; in_valid = 1'b1;
        for (int n = 0; n < LIMIT && !acc; n++) begin
            #2;
            if (in_ready) acc = 1;
            else @(negedge clk);
        end
        check("accept", cv_t'(acc), cv_t'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0; in_valid = 1'b0; in_line = '0; in_last = 1'b0; in_ctrl = 1'b0;
        in_mode = '0; in_pu = '0; in_cluster = '0; in_bcast = 1'b0;
        out_ready = 4'hF; order_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        // 1: five single-line tuples back-to-back
        for (int i = 0; i < 5; i++) send(rl(), 1'b1, 1'b0, 2'(i), 3'(i), 2'd3, 1'b1);
        idle(1); #2;
        check("t1_tuples", cv_t'(tuples_dispatched), cv_t'(5));

        // 2: 3-line tuple to cluster 1 with cluster 1 stalled after line 1
        send(rl(), 1'b0, 1'b0, 2'd1, 3'd1, 2'd0, 1'b0);
        fork
            send(rl(), 1'b0, 1'b0, 2'd2, 3'd2, 2'd0, 1'b0);
            begin
                @(negedge clk);
                out_ready = 4'b1101;
                #2 check("t2_stall", cv_t'(in_ready), cv_t'(0));
                repeat (4) @(negedge clk);
                out_ready = 4'hF;
            end
        join
        send(rl(), 1'b1, 1'b0, 2'd3, 3'd3, 2'd0, 1'b0);

        // 3: 2-line broadcast with cluster 2 slow
        send(rl(), 1'b0, 1'b1, 2'd1, 3'd5, 2'd0, 1'b1);
        fork
            send(rl(), 1'b1, 1'b1, 2'd2, 3'd6, 2'd1, 1'b0);
            begin
                @(negedge clk);
                out_ready = 4'b1011;
                #2 check("t3_stall", cv_t'(in_ready), cv_t'(0));
                @(negedge clk);
                #2 check("t3_partial", cv_t'(out_valid), cv_t'(4'b0100));
                repeat (2) @(negedge clk);
                out_ready = 4'hF;
            end
        join
        idle(1); #2;
        check("t3_prog_lines", cv_t'(prog_lines), cv_t'(2));
        send(rl(), 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0);
        idle(1); #2;
        check("t3_rr_kept", cv_t'(out_valid), cv_t'(4'b0100));

        // 4: tuple, unicast programming to cluster 3, tuple
        order_ready = 1'b0;
        do_reset();
        send(rl(), 1'b1, 1'b0, 2'd0, 3'd0, 2'd2, 1'b1);
        send(rl(), 1'b1, 1'b1, 2'd3, 3'd7, 2'd3, 1'b0);
        send(rl(), 1'b1, 1'b0, 2'd0, 3'd0, 2'd3, 1'b1);
        idle(1); #2;
        check("t4_order_valid", cv_t'(order_valid), cv_t'(1));
        check("t4_order_head", cv_t'(order_out), cv_t'(0));
        order_ready = 1'b1;
        idle(3);

        // 5: fill the order FIFO, 65th tuple stalls until one pop
        order_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 64; i++) send(rl(), 1'b1, 1'b0, 2'(i), 3'(i), 2'd0, 1'b0);
        @(negedge clk);
        in_line = rl(); in_last = 1'b1; in_ctrl = 1'b0; in_valid = 1'b1;
        #2 check("t5_full_stall", cv_t'(in_ready), cv_t'(0));
        @(negedge clk);
        order_ready = 1'b1;
        #2 check("t5_stall_during_pop", cv_t'(in_ready), cv_t'(0));
        check("t5_pop_head", cv_t'(order_out), cv_t'(0));
        @(negedge clk);
        order_ready = 1'b0;
        #2 check("t5_accept_after_pop", cv_t'(in_ready), cv_t'(1));
        @(negedge clk);
        in_valid = 1'b0;
        order_ready = 1'b1;
        idle(70);

        // 6: reset in the middle of a 4-line tuple
        do_reset();
        send(rl(), 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0);
        send(rl(), 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0);
        do_reset();
        #2;
        check("t6_out_valid", cv_t'(out_valid), cv_t'(0));
        check("t6_order_valid", cv_t'(order_valid), cv_t'(0));
        check("t6_tuples", cv_t'(tuples_dispatched), cv_t'(0));
        check("t6_prog", cv_t'(prog_lines), cv_t'(0));
        send(rl(), 1'b1, 1'b0, 2'd1, 3'd1, 2'd2, 1'b1);
        idle(1); #2;
        check("t6_cluster0", cv_t'(out_valid), cv_t'(4'b0001));

        // Randomized traffic with random back-pressure
        fork
            begin
                for (int m = 0; m < 200; m++) begin
                    bit prog;
                    int len;
                    prog = ($urandom_range(3) == 0);
                    len  = $urandom_range(4, 1);
                    for (int i = 0; i < len; i++)
                        send(rl(), logic'(i == len - 1), prog, 2'($urandom_range(3)),
                             3'($urandom_range(7)), 2'($urandom_range(3)), 1'($urandom_range(1)));
                    if ($urandom_range(4) == 0) idle(1);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    for (int k = 0; k < NC; k++) out_ready[k] = ($urandom_range(3) != 0);
                    order_ready = 1'($urandom_range(1));
                end
            end
        join

        out_ready = 4'hF;
        order_ready = 1'b1;
        idle(80);
        #2;
        for (int k = 0; k < NC; k++)
            check($sformatf("drain_cluster%0d", k), cv_t'(exp_q[k].size()), cv_t'(0));
        check("drain_order", cv_t'(order_valid), cv_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
